ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle control unit for the 16-bit-instruction / 8-bit-datapath CPU. It fetches instructions over a req/ack handshake, holds the program counter and instruction register, and sequences fetch/decode/execute/memory/writeback. It drives every datapath steering signal, including the 2:1 operand-select mux in front of the ALU (`alu_src_sel`), the writeback-source select, the register write enable and the data-memory strobes.

## Interface
Parameters: none (widths fixed by the ISA).

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  instruction fetch request
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  16  instruction word
- `pc`  out  8  fetch address
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  1 = store, 0 = load
- `dmem_addr`  out  8  data address (= imm)
- `dmem_ack`  in  1  data access complete
- `rd_addr`  out  4  destination / store-source register
- `rs_addr`  out  4  source register
- `imm`  out  8  IR[7:0]
- `alu_op`  out  3  ALU function
- `alu_src_sel`  out  1  ALU operand-B select: 0 = rs data, 1 = imm
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = imm, 2 = dmem
- `reg_we`  out  1  register file write strobe
- `zero_in`  in  1  ALU zero result
- `halted`  out  1  core is in HALT
- `illegal`  out  1  illegal opcode trapped (0 when macro absent)

## Operation
- Instruction format: op = IR[15:12], rd = IR[11:8], rs = IR[7:4], imm = IR[7:0].
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd ← rd op rs).
  - 6 ADDI (rd ← rd + imm).
  - 7 LDI (rd ← imm).
  - 8 LD (rd ← mem[imm]); 9 ST (mem[imm] ← rd).
  - A JMP (pc ← imm); B BZ (if Z, pc ← imm).
  - C–E illegal; F HALT.
- `alu_op`: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4. ADDI uses ADD with `alu_src_sel` = 1.
- States:
  - BOOT → FETCH.
  - FETCH: hold until `imem_ack`, then go to DECODE.
  - DECODE → EXEC.
  - EXEC: ALU ops and LDI → WB; LD/ST → MEM; NOP/JMP/BZ → FETCH; HALT → HALT.
  - MEM: hold until `dmem_ack`; LD → WB, ST → FETCH.
  - WB → FETCH.
  - HALT is absorbing.
- On the `imem_ack` edge: IR ← `imem_rdata`, pc ← pc + 1 (mod 256; 0xFF wraps to 0x00).
- Z flag: updated from `zero_in` at the end of EXEC for opcodes 1–6 only. Z is not updated by LDI, LD or any other opcode.
- JMP and BZ load pc at the end of EXEC, overriding the increment done during fetch.

## Timing
- Outputs are Moore: decoded from state + IR only, with no combinational path from any input.
- Reset values:
  - state BOOT, pc 0x00, IR 0x0000, Z 0.
  - `imem_req`, `dmem_req`, `dmem_we`, `reg_we`, `halted`, `illegal` all 0.
  - `alu_op` 0, `alu_src_sel` 0, `wb_sel` 0.
  - `rd_addr`, `rs_addr`, `imm` 0.
- `imem_req` is high for every FETCH cycle. It drops the cycle after ack is sampled.
- Ack is allowed in the first req cycle, so zero-wait FETCH is 1 cycle. The same rules apply to `dmem_req`/`dmem_ack`.
- `dmem_we` is valid with `dmem_req`. `rd_addr` is held during ST so the register file supplies store data.
- `reg_we` is high exactly one cycle (WB). `wb_sel` is stable in WB.
- `alu_op`/`alu_src_sel` are stable from DECODE through WB.
- Instruction cycle counts with zero-wait memory:
  - ALU/LDI: 4.
  - LD: 5.
  - ST: 4.
  - NOP/JMP/BZ: 3.
- Reset asserted mid-operation returns to BOOT immediately. Outstanding req is dropped; memories must tolerate an abandoned request.
- `halted` is high in every HALT cycle. Acks arriving outside FETCH/MEM are ignored.

## Configuration
- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- Defined: opcodes C–E go to HALT from EXEC, with `illegal` set sticky until reset and `halted` asserted.
- Undefined: opcodes C–E execute as NOP; `illegal` is tied 0.

## Structure
- Package `ctrl_pkg`:
  - opcode enum, state enum.
  - `alu_op` codes, `wb_sel` codes.
  - field bit-position constants.
- Sub-module `ctrl_decode`: combinational IR → {`alu_op`, `alu_src_sel`, `wb_sel`, class flags}. The FSM keeps state, pc, IR and Z.

## Test plan
- **Reset:** assert `rst`, release, zero-wait memory → BOOT for one cycle, then `imem_req` = 1 with pc = 0x00.
- **ADDI / ADD:** IR 0x6105 then 0x1120, zero-wait.
  - ADDI: `alu_src_sel` = 1, `alu_op` = 0, `reg_we` pulse on cycle 4 with `rd_addr` = 1.
  - ADD: `alu_src_sel` = 0, `rs_addr` = 2.
- **LD with waits:** LD 0x8340 with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles, `dmem_addr` = 0x40, `dmem_we` = 0, then WB with `wb_sel` = 2, `rd_addr` = 3.
- **BZ both ways:**
  - SUB with `zero_in` = 1, then BZ 0xB010 → next pc = 0x10.
  - With `zero_in` = 0 → pc continues sequentially.
  - LDI between SUB and BZ leaves Z unchanged.
- **Wrap and jump:** at pc = 0xFF a NOP fetch → pc = 0x00; JMP 0xA0FF → pc = 0xFF.
- **Illegal and HALT:** IR 0xC000 → with `CTRL_ILLEGAL_TRAP_EN`, `illegal` = 1 and `halted` = 1 with no further `imem_req`; without the macro, treated as NOP. IR 0xF000 → `halted` = 1 indefinitely until reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM states, ALU/writeback codes and IR field positions
package ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6, OP_LDI = 4'h7,
    OP_LD   = 4'h8, OP_ST  = 4'h9, OP_JMP = 4'hA, OP_BZ  = 4'hB,
    OP_IL0  = 4'hC, OP_IL1 = 4'hD, OP_IL2 = 4'hE, OP_HALT = 4'hF
  } opcode_e;
  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode -> ALU steering, writeback select and class flags
module ctrl_decode import ctrl_pkg::*; (
  input  logic [3:0] op,
  output logic [2:0] alu_op,
  output logic       alu_src_sel,
  output logic [1:0] wb_sel,
  output logic       is_wb,
  output logic       is_mem,
  output logic       is_ld,
  output logic       is_st,
  output logic       is_jmp,
  output logic       is_bz,
  output logic       is_halt,
  output logic       upd_z
);
  opcode_e o;
  // opcode classification; alu_op stays ADD for everything but the logic/sub ops
  always_comb begin
    o           = opcode_e'(op);
    alu_op      = o == OP_SUB ? ALU_SUB : o == OP_AND ? ALU_AND :
                  o == OP_OR  ? ALU_OR  : o == OP_XOR ? ALU_XOR : ALU_ADD;
    alu_src_sel = o == OP_ADDI;
    wb_sel      = o == OP_LDI ? WB_IMM : o == OP_LD ? WB_MEM : WB_ALU;
    upd_z       = o inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI};
    is_wb       = upd_z || o == OP_LDI;
    is_ld       = o == OP_LD;
    is_st       = o == OP_ST;
    is_mem      = is_ld || is_st;
    is_jmp      = o == OP_JMP;
    is_bz       = o == OP_BZ;
    is_halt     = o == OP_HALT;
  end
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute control unit; CTRL_ILLEGAL_TRAP_EN traps opcodes C-E into HALT
module ctrl_fsm import ctrl_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [7:0]  pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  input  logic        dmem_ack,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs_addr,
  output logic [7:0]  imm,
  output logic [2:0]  alu_op,
  output logic        alu_src_sel,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  input  logic        zero_in,
  output logic        halted,
  output logic        illegal
);
  state_e      state, nxt;
  logic [15:0] ir;
  logic        z, trap;
  logic        is_wb, is_mem, is_ld, is_st, is_jmp, is_bz, is_halt, upd_z;

  ctrl_decode u_dec (
    .op(ir[OP_LSB+:4]), .alu_op(alu_op), .alu_src_sel(alu_src_sel), .wb_sel(wb_sel),
    .is_wb(is_wb), .is_mem(is_mem), .is_ld(is_ld), .is_st(is_st),
    .is_jmp(is_jmp), .is_bz(is_bz), .is_halt(is_halt), .upd_z(upd_z)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = ir[OP_LSB+:4] inside {OP_IL0, OP_IL1, OP_IL2};
  // sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) illegal <= 1'b0;
    else if (state == S_EXEC && trap) illegal <= 1'b1;
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_BOOT;
    else state <= nxt;

  // next-state sequencing
  always_comb begin
    nxt = state;
    case (state)
      S_BOOT:   nxt = S_FETCH;
      S_FETCH:  nxt = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = (is_halt || trap) ? S_HALT : is_wb ? S_WB : is_mem ? S_MEM : S_FETCH;
      S_MEM:    nxt = !dmem_ack ? S_MEM : is_ld ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_BOOT;
    endcase
  end

  // program counter, instruction register and zero flag; branches override the fetch increment
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= 8'h00;
      ir <= 16'h0000;
      z  <= 1'b0;
    end else begin
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + 8'd1;
      end
      if (state == S_EXEC && upd_z) z <= zero_in;
      if (state == S_EXEC && (is_jmp || (is_bz && z))) pc <= ir[IMM_LSB+:8];
    end

  // Moore outputs from state and IR only
  always_comb begin
    imem_req  = state == S_FETCH;
    dmem_req  = state == S_MEM;
    dmem_we   = state == S_MEM && is_st;
    reg_we    = state == S_WB;
    halted    = state == S_HALT;
    rd_addr   = ir[RD_LSB+:4];
    rs_addr   = ir[RS_LSB+:4];
    imm       = ir[IMM_LSB+:8];
    dmem_addr = ir[IMM_LSB+:8];
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized instruction-level checking of ctrl_fsm against an ISA-level reference model
module tb_ctrl_fsm;
  logic        clk = 0, rst = 0;
  logic        imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, zero_in = 0;
  logic [15:0] imem_rdata = 0;
  logic [7:0]  pc, dmem_addr, imm;
  logic [3:0]  rd_addr, rs_addr;
  logic [2:0]  alu_op;
  logic        alu_src_sel, reg_we, halted, illegal;
  logic [1:0]  wb_sel;
  int          checks = 0, errors = 0;
  logic [7:0]  m_pc;
  bit          m_z;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm), .alu_op(alu_op), .alu_src_sel(alu_src_sel),
    .wb_sel(wb_sel), .reg_we(reg_we), .zero_in(zero_in), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic noise;
    imem_ack   = 1'($urandom);
    dmem_ack   = 1'($urandom);
    imem_rdata = 16'($urandom);
  endtask

  function automatic logic [2:0] ref_alu(input logic [3:0] op);
    case (op)
      4'h2: return 3'd1;
      4'h3: return 3'd2;
      4'h4: return 3'd3;
      4'h5: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic do_reset;
    rst = 1; imem_ack = 0; dmem_ack = 0;
    step; step;
    checks++;
    if ({imem_req, dmem_req, dmem_we, reg_we, halted, illegal, alu_op, alu_src_sel, wb_sel,
         rd_addr, rs_addr, imm, pc, dmem_addr} !== 44'h0) begin
      errors++;
      $display("FAIL reset_values got req=%b dreq=%b we=%b rwe=%b hlt=%b ill=%b alu=%h src=%b wb=%h rd=%h rs=%h imm=%h pc=%h exp all zero",
               imem_req, dmem_req, dmem_we, reg_we, halted, illegal, alu_op, alu_src_sel, wb_sel, rd_addr, rs_addr, imm, pc);
    end
    rst = 0;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_cycle imem_req got %b exp 0", imem_req); end
    step;
    m_pc = 8'h00;
    m_z  = 0;
  endtask

  // Runs one instruction from its first FETCH cycle, checking every cycle against the ISA rules.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input bit zv);
    logic [3:0] op;
    bit         trap, alu, halt;
    op   = ins[15:12];
    trap = TRAP && op >= 4'hC && op <= 4'hE;
    alu  = op >= 4'h1 && op <= 4'h6;
    halt = trap || op == 4'hF;
    zero_in = zv;
    for (int i = 0; i <= fw; i++) begin
      checks++;
      if ({imem_req, pc, halted, illegal} !== {1'b1, m_pc, 2'b00}) begin
        errors++;
        $display("FAIL fetch ins=%h cyc=%0d got req=%b pc=%h hlt=%b ill=%b exp req=1 pc=%h", ins, i, imem_req, pc, halted, illegal, m_pc);
      end
      noise;
      imem_ack = (i == fw);
      if (i == fw) imem_rdata = ins;
      step;
    end
    m_pc = m_pc + 8'd1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({imem_req, dmem_req, reg_we, halted, rd_addr, rs_addr, imm} !== {4'b0000, ins[11:8], ins[7:4], ins[7:0]}) begin
        errors++;
        $display("FAIL dec_exec ins=%h cyc=%0d got req=%b dreq=%b rwe=%b hlt=%b rd=%h rs=%h imm=%h", ins, k, imem_req, dmem_req, reg_we, halted, rd_addr, rs_addr, imm);
      end
      if (alu) begin
        checks++;
        if ({alu_op, alu_src_sel} !== {ref_alu(op), op == 4'h6}) begin
          errors++;
          $display("FAIL alu_ctrl ins=%h got op=%h src=%b exp op=%h src=%b", ins, alu_op, alu_src_sel, ref_alu(op), op == 4'h6);
        end
      end
      noise;
      step;
    end
    if (alu) m_z = zv;
    if (op == 4'hA || (op == 4'hB && m_z)) m_pc = ins[7:0];
    if (halt) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if ({halted, illegal, imem_req, dmem_req, reg_we} !== {1'b1, trap, 3'b000}) begin
          errors++;
          $display("FAIL halt ins=%h cyc=%0d got hlt=%b ill=%b req=%b dreq=%b rwe=%b exp hlt=1 ill=%b", ins, k, halted, illegal, imem_req, dmem_req, reg_we, trap);
        end
        noise;
        step;
      end
      return;
    end
    if (op == 4'h8 || op == 4'h9) begin
      for (int j = 0; j <= mw; j++) begin
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, reg_we, imem_req, rd_addr} !== {1'b1, op == 4'h9, ins[7:0], 2'b00, ins[11:8]}) begin
          errors++;
          $display("FAIL mem ins=%h cyc=%0d got dreq=%b we=%b addr=%h rwe=%b req=%b rd=%h", ins, j, dmem_req, dmem_we, dmem_addr, reg_we, imem_req, rd_addr);
        end
        noise;
        dmem_ack = (j == mw);
        step;
      end
    end
    if (alu || op == 4'h7 || op == 4'h8) begin
      checks++;
      if ({reg_we, wb_sel, rd_addr, dmem_req, imem_req} !== {1'b1, op == 4'h8 ? 2'd2 : op == 4'h7 ? 2'd1 : 2'd0, ins[11:8], 2'b00}) begin
        errors++;
        $display("FAIL wb ins=%h got rwe=%b wb=%h rd=%h dreq=%b req=%b", ins, reg_we, wb_sel, rd_addr, dmem_req, imem_req);
      end
      if (alu) begin
        checks++;
        if ({alu_op, alu_src_sel} !== {ref_alu(op), op == 4'h6}) begin
          errors++;
          $display("FAIL wb_alu ins=%h got op=%h src=%b exp op=%h", ins, alu_op, alu_src_sel, ref_alu(op));
        end
      end
      noise;
      step;
    end
  endtask

  task automatic test_reset;
    do_reset;
  endtask

  task automatic test_addi_add;
    run_instr(16'h6105, 0, 0, 0);
    run_instr(16'h1120, 0, 0, 1);
  endtask

  task automatic test_ld_wait;
    run_instr(16'h8340, 0, 3, 0);
    run_instr(16'h9540, 2, 1, 0);
  endtask

  task automatic test_bz;
    run_instr(16'h2110, 0, 0, 1);
    run_instr(16'hB010, 0, 0, 0);
    run_instr(16'h2110, 1, 0, 0);
    run_instr(16'h7233, 0, 0, 1);
    run_instr(16'hB077, 0, 0, 1);
    run_instr(16'h3110, 0, 0, 1);
    run_instr(16'h7200, 0, 0, 0);
    run_instr(16'h8200, 0, 0, 0);
    run_instr(16'hB066, 0, 0, 0);
  endtask

  task automatic test_wrap_jump;
    run_instr(16'hA0FF, 0, 0, 0);
    run_instr(16'h0000, 0, 0, 0);
    run_instr(16'h0123, 1, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, TRAP ? 11 : 14));
      run_instr({op, 12'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    run_instr(16'h2000, 0, 0, 1);
    imem_ack = 0;
    step;
    #2 rst = 1;
    #1;
    checks++;
    if ({imem_req, pc, halted} !== 10'h0) begin
      errors++;
      $display("FAIL async_reset got req=%b pc=%h hlt=%b exp all 0", imem_req, pc, halted);
    end
    @(posedge clk);
    #1 rst = 0;
    step;
    m_pc = 8'h00;
    m_z  = 0;
    run_instr(16'hB050, 0, 0, 0);
  endtask

  task automatic test_illegal_halt;
    run_instr(16'hC000, 0, 0, 0);
    if (TRAP) do_reset;
    run_instr(16'hE0AB, 1, 0, 0);
    if (TRAP) do_reset;
    run_instr(16'hF000, 0, 0, 0);
    do_reset;
    run_instr(16'h7101, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_addi_add;
    test_ld_wait;
    test_bz;
    test_wrap_jump;
    test_random;
    test_reset_mid;
    test_illegal_halt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
